imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Pipelined, parametrised immediate generator sitting between instruction fetch and register read in the next-generation core. Decodes the immediate of every RV32I/RV64I base format (I, S, B, U, J), flags unrecognised opcodes, and registers the result behind a valid/ready handshake with a 2-entry skid buffer. The buffer lets decode stall without creating a combinational ready path back to fetch.

## Interface
- XLEN, 32, datapath width of `out_imm` and the PC tag; legal values are 32 and 64.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline flush; discards all buffered entries.
- in_valid  input  1  `in_instr` and `in_pc` are valid.
- in_ready  output  1  block can accept an instruction this cycle.
- in_instr  input  32  raw 32-bit instruction word.
- in_pc  input  XLEN  PC tag, passed through unchanged.
- out_valid  output  1  output entry is valid.
- out_ready  input  1  consumer accepts the output entry this cycle.
- out_imm  output  XLEN  decoded immediate.
- out_fmt  output  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z; 7 is reserved and never driven.
- out_illegal  output  1  opcode not recognised, or `in_instr[1:0] != 2'b11`.
- out_pc  output  XLEN  PC tag of the output entry.

## Operation
**Opcode decode**
- 0010011, 0000011, 1100111 (JALR), 0001111 (FENCE) → I; imm = sext(instr[31:20]).
- 0100011 → S; imm = sext({instr[31:25], instr[11:7]}).
- 1100011 → B; imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
- 0110111, 0010111 → U; imm = sext({instr[31:12], 12'b0}).
  - With XLEN=64, bit 31 is replicated into bits 63:32.
- 1101111 → J; imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- 0110011 (R-type) → NONE; imm = 0.
- 1110011 (SYSTEM) → see Configuration.
- Any other opcode, or `instr[1:0] != 2'b11` → `out_illegal=1`, fmt NONE, imm 0.
- All sign extension (sext) is to XLEN bits.

**Buffer**
- Entries are {imm, fmt, illegal, pc}.
- Two slots, MAIN (drives the outputs) and SKID.
- States: EMPTY, ONE (MAIN valid), TWO (MAIN and SKID valid).
- acc = in_valid & in_ready; deq = out_valid & out_ready.
- State transitions:
  - EMPTY: acc → ONE.
  - ONE: acc & !deq → TWO; !acc & deq → EMPTY; acc & deq → ONE, MAIN loads the new entry.
  - TWO: deq → ONE, SKID moves to MAIN. `in_ready` is low, so acc cannot occur.
- Strict FIFO order; entries are never dropped or duplicated.
- `out_valid` = state != EMPTY; `in_ready` = state != TWO. Both are purely registered.
- While `out_valid & !out_ready`, all outputs hold stable.

**Flush and reset**
- flush: next state EMPTY; any input accepted in the same cycle is discarded.
- rst has priority over flush.
- Reset values: `out_valid=0`, `in_ready=1` (state EMPTY), `out_imm=0`, `out_fmt=0`, `out_illegal=0`, `out_pc=0`.
- Input presented while rst is high is discarded.
- Reset mid-stall empties both slots without waiting for `out_ready`.

## Timing
- Latency is 1 cycle: an entry accepted at edge N is visible on the outputs after edge N.
- Throughput is 1 entry/cycle while `out_ready` stays high.
- After `out_ready` falls, up to 2 entries are absorbed before `in_ready` drops.
- `in_ready` rises the cycle after the first deq from TWO.
- No combinational path from `out_ready` to `in_ready`, or from inputs to outputs.

## Configuration
- `IMM_GEN_ZICSR_EN` defined, SYSTEM opcode decodes by funct3:
  - funct3 ∈ {101, 110, 111} → Z; imm = zext(instr[19:15]).
  - funct3 ∈ {001, 010, 011} → I; imm = zext(instr[31:20]) (CSR address).
  - funct3 = 000 → NONE; imm 0.
  - funct3 = 100 → illegal.
- `IMM_GEN_ZICSR_EN` undefined: SYSTEM → NONE, imm 0, not illegal. fmt Z is never produced.

## Structure
- Package `imm_gen_pkg` holds:
  - opcode localparams (OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_FENCE, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP, OPC_SYSTEM);
  - 3-bit format codes FMT_NONE..FMT_Z;
  - buffer state encoding.
- Sub-module `imm_decode`: purely combinational, instr → {imm, fmt, illegal}, parametrised by XLEN.
- The top level instantiates `imm_decode` once on the input side, followed by the skid buffer.

## Test plan
- Format decode, XLEN=32, `out_ready=1`, one instruction per cycle, each result 1 cycle later:
  - 0xFFF00093 → imm 0xFFFFFFFF, fmt I.
  - 0xFE112E23 → imm 0xFFFFFFFC, fmt S.
  - 0x00000863 → imm 0x00000010, fmt B.
  - 0x00008067 → imm 0, fmt I, `out_illegal=0`.
- XLEN=64, 0x800002B7 (LUI) → imm 0xFFFFFFFF80000000, fmt U.
  - 0x00000000 → `out_illegal=1`, imm 0, fmt NONE.
- 0x3002D073 (csrrwi x0, 0x300, 5):
  - macro defined → fmt Z, imm 5;
  - macro undefined → fmt NONE, imm 0, `out_illegal=0`.
- Backpressure: hold `out_ready=0` and offer 3 instructions (pc 0x0, 0x4, 0x8) back-to-back.
  - Two are accepted, `in_ready=0` on the third.
  - `out_pc` holds 0x0 stable.
  - Raise `out_ready` → outputs 0x0, 0x4, 0x8 in order.
  - `in_ready` returns 1 one cycle after the first deq.
- Flush in state TWO with `in_valid=1` → next cycle `out_valid=0`, `in_ready=1`; the offered entry never appears.
- rst asserted mid-stall (state TWO) → next cycle all outputs at reset values, `in_ready=1`.
  - Deasserted with input 0xFFF00093 → output one cycle later, imm 0xFFFFFFFF.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared constants for the immediate generator.
// Holds the RV32I/RV64I major opcodes, the 3-bit format codes reported on
// out_fmt, the skid-buffer state encoding and a small decode helper.
package imm_gen_pkg;

    // Major opcodes (instr[6:0]) that carry or imply an immediate format
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Format codes; 3'd7 is reserved and never produced
    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;

    // Occupancy of the two-slot output buffer
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,   // no entry held
        BUF_ONE   = 2'd1,   // MAIN valid
        BUF_TWO   = 2'd2    // MAIN and SKID valid
    } buf_state_t;

    // 32-bit base-ISA encodings always have the two low bits set;
    // anything else is a compressed or invalid encoding.
    function automatic logic is_base_quadrant(input logic [31:0] instr);
        return instr[1:0] == 2'b11;
    endfunction

endpackage

// File: rtl/imm_decode.sv
// imm_decode: purely combinational immediate extraction.
// Maps a raw 32-bit instruction to {imm, fmt, illegal}. Immediates are first
// assembled as 32-bit sign-extended values and then widened to XLEN, so the
// XLEN=64 build replicates bit 31 into the upper word.
// Build option: define IMM_GEN_ZICSR_EN to decode SYSTEM CSR instructions
// (fmt I for CSR address, fmt Z for the 5-bit uimm). Without it SYSTEM is a
// legal NONE-format opcode.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    // Field scrambles of each base format, sign-extended to 32 bits
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    // Widen a 32-bit two's-complement value to XLEN bits
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    // Opcode decode: select the format and its immediate, flag unknown opcodes
    always_comb begin
        imm     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        if (!is_base_quadrant(instr)) begin
            illegal = 1'b1;
        end else begin
            case (instr[6:0])
                OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_FENCE: begin
                    fmt = FMT_I;
                    imm = sext32(imm_i);
                end
                OPC_STORE: begin
                    fmt = FMT_S;
                    imm = sext32(imm_s);
                end
                OPC_BRANCH: begin
                    fmt = FMT_B;
                    imm = sext32(imm_b);
                end
                OPC_LUI, OPC_AUIPC: begin
                    fmt = FMT_U;
                    imm = sext32(imm_u);
                end
                OPC_JAL: begin
                    fmt = FMT_J;
                    imm = sext32(imm_j);
                end
                OPC_OP: begin
                    fmt = FMT_NONE;
                end
                OPC_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
                    // funct3 selects register-source CSR ops (CSR address as
                    // an unsigned I immediate) or immediate-source ops (uimm)
                    case (instr[14:12])
                        3'b101, 3'b110, 3'b111: begin
                            fmt = FMT_Z;
                            imm = XLEN'(instr[19:15]);
                        end
                        3'b001, 3'b010, 3'b011: begin
                            fmt = FMT_I;
                            imm = XLEN'(instr[31:20]);
                        end
                        3'b100: begin
                            illegal = 1'b1;
                        end
                        default: begin
                            fmt = FMT_NONE;
                        end
                    endcase
`else
                    fmt = FMT_NONE;
`endif
                end
                default: begin
                    illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: immediate generator with a registered two-slot skid buffer.
// The decoder sits on the input side; its result plus the PC tag is captured
// into MAIN (drives the outputs) or SKID. in_ready and out_valid are flops,
// so there is no combinational path from out_ready to in_ready nor from any
// input to any output.
// Build option: IMM_GEN_ZICSR_EN enables CSR immediate decode (see imm_decode).
//
// Handshake: an input is taken on a rising edge where in_valid & in_ready;
// an output is consumed on a rising edge where out_valid & out_ready. While
// out_valid is high and out_ready is low every output holds its value. The
// producer may change or drop in_valid at will; nothing is taken unless both
// signals are high at the edge.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc,
    output buf_state_t      dbg_state
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } entry_t;

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;
    entry_t          dec_entry;

    entry_t     main_q;
    entry_t     skid_q;
    buf_state_t state_q;
    logic       in_ready_q;
    logic       out_valid_q;

    logic acc;
    logic deq;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    // Decoded entry as it would be written into a buffer slot
    always_comb begin
        dec_entry         = '0;
        dec_entry.imm     = dec_imm;
        dec_entry.fmt     = dec_fmt;
        dec_entry.illegal = dec_illegal;
        dec_entry.pc      = in_pc;
    end

    assign acc = in_valid & in_ready_q;
    assign deq = out_valid_q & out_ready;

    // Buffer FSM: occupancy, slot contents and the registered handshake flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BUF_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            // Slot contents are left as-is; they are invisible once empty
            state_q     <= BUF_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (acc) begin
                        main_q      <= dec_entry;
                        state_q     <= BUF_ONE;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                    end
                end
                BUF_ONE: begin
                    if (acc && !deq) begin
                        // Consumer stalled: park the new entry behind MAIN
                        skid_q      <= dec_entry;
                        state_q     <= BUF_TWO;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else if (!acc && deq) begin
                        state_q     <= BUF_EMPTY;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end else if (acc && deq) begin
                        // Streaming: replace MAIN in place
                        main_q <= dec_entry;
                    end
                end
                BUF_TWO: begin
                    // in_ready is low here, so only a dequeue can happen
                    if (deq) begin
                        main_q      <= skid_q;
                        state_q     <= BUF_ONE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= BUF_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Outputs come straight from flops
    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;
    assign out_pc      = main_q.pc;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: bench for imm_gen_pipe. Two instances (XLEN=32 and
// XLEN=64) share one stimulus stream; the 32-bit instance is expected to
// show the low word of every 64-bit expectation. Honours IMM_GEN_ZICSR_EN.
`timescale 1ns/1ps
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    localparam int W = 132;   // {imm[63:0], fmt[2:0], illegal, pc[63:0]}

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        in_ready32, out_valid32, ill32;
    logic [31:0] imm32, pc32;
    logic [2:0]  fmt32;
    buf_state_t  st32;

    logic        in_ready64, out_valid64, ill64;
    logic [63:0] imm64, pc64;
    logic [2:0]  fmt64;
    buf_state_t  st64;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;
    vec_t vecs[16];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1);
    end

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk (clk), .rst (rst), .flush (flush),
        .in_valid (in_valid), .in_ready (in_ready32),
        .in_instr (in_instr), .in_pc (in_pc[31:0]),
        .out_valid (out_valid32), .out_ready (out_ready),
        .out_imm (imm32), .out_fmt (fmt32), .out_illegal (ill32),
        .out_pc (pc32), .dbg_state (st32)
    );

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk (clk), .rst (rst), .flush (flush),
        .in_valid (in_valid), .in_ready (in_ready64),
        .in_instr (in_instr), .in_pc (in_pc),
        .out_valid (out_valid64), .out_ready (out_ready),
        .out_imm (imm64), .out_fmt (fmt64), .out_illegal (ill64),
        .out_pc (pc64), .dbg_state (st64)
    );

    // ---------------- reference model ----------------
    // Immediate value computed as a signed integer from the field weights.
    function automatic logic [W-1:0] ref_entry(input logic [31:0] ins, input logic [63:0] pc);
        longint v;
        logic [2:0] f;
        logic ill;
        v = 0;
        f = FMT_NONE;
        ill = 1'b0;
        if (ins[1:0] != 2'b11) begin
            ill = 1'b1;
        end else begin
            case (ins[6:0])
                7'h13, 7'h03, 7'h67, 7'h0F: begin
                    f = FMT_I;
                    v = longint'(ins[31:20]) - (ins[31] ? 4096 : 0);
                end
                7'h23: begin
                    f = FMT_S;
                    v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]) - (ins[31] ? 4096 : 0);
                end
                7'h63: begin
                    f = FMT_B;
                    v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                        + longint'(ins[11:8]) * 2 - (ins[31] ? 4096 : 0);
                end
                7'h37, 7'h17: begin
                    f = FMT_U;
                    v = longint'(ins[31:12]) * 4096 - (ins[31] ? 64'sd4294967296 : 64'sd0);
                end
                7'h6F: begin
                    f = FMT_J;
                    v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                        + longint'(ins[30:21]) * 2 - (ins[31] ? 1048576 : 0);
                end
                7'h33: f = FMT_NONE;
                7'h73: begin
`ifdef IMM_GEN_ZICSR_EN
                    if (ins[14:12] >= 3'd5) begin
                        f = FMT_Z;
                        v = longint'(ins[19:15]);
                    end else if (ins[14:12] >= 3'd1 && ins[14:12] <= 3'd3) begin
                        f = FMT_I;
                        v = longint'(ins[31:20]);
                    end else if (ins[14:12] == 3'd4) begin
                        ill = 1'b1;
                    end
`else
                    f = FMT_NONE;
`endif
                end
                default: ill = 1'b1;
            endcase
        end
        return {64'(v), f, ill, pc};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 7) != 0) begin
            case ($urandom_range(0, 10))
                0: r[6:0] = 7'h13;
                1: r[6:0] = 7'h03;
                2: r[6:0] = 7'h67;
                3: r[6:0] = 7'h0F;
                4: r[6:0] = 7'h23;
                5: r[6:0] = 7'h63;
                6: r[6:0] = 7'h37;
                7: r[6:0] = 7'h17;
                8: r[6:0] = 7'h6F;
                9: r[6:0] = 7'h33;
                default: r[6:0] = 7'h73;
            endcase
        end
        return r;
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_flags(input string name, input logic exp_valid, input logic exp_ready);
        check({name, "_out_valid32"}, 64'(out_valid32), 64'(exp_valid));
        check({name, "_out_valid64"}, 64'(out_valid64), 64'(exp_valid));
        check({name, "_in_ready32"},  64'(in_ready32),  64'(exp_ready));
        check({name, "_in_ready64"},  64'(in_ready64),  64'(exp_ready));
    endtask

    task automatic check_entry(input string name, input logic [W-1:0] e);
        check({name, "_imm32"}, 64'(imm32), 64'(e[99:68]));
        check({name, "_imm64"}, imm64, e[131:68]);
        check({name, "_fmt32"}, 64'(fmt32), 64'(e[67:65]));
        check({name, "_fmt64"}, 64'(fmt64), 64'(e[67:65]));
        check({name, "_ill32"}, 64'(ill32), 64'(e[64]));
        check({name, "_ill64"}, 64'(ill64), 64'(e[64]));
        check({name, "_pc32"},  64'(pc32),  64'(e[31:0]));
        check({name, "_pc64"},  pc64, e[63:0]);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic offer(input logic [31:0] ins, input logic [63:0] pc);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc = pc;
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic [W-1:0] e;
        logic a, d;
        int sz;

        in_instr = '0;
        in_pc = '0;

        vecs[0]  = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, FMT_I, 1'b0};
        vecs[1]  = '{32'hFE112E23, 64'hFFFF_FFFF_FFFF_FFFC, FMT_S, 1'b0};
        vecs[2]  = '{32'h00000863, 64'h0000_0000_0000_0010, FMT_B, 1'b0};
        vecs[3]  = '{32'h00008067, 64'h0, FMT_I, 1'b0};
        vecs[4]  = '{32'h800002B7, 64'hFFFF_FFFF_8000_0000, FMT_U, 1'b0};
        vecs[5]  = '{32'h00000000, 64'h0, FMT_NONE, 1'b1};
        vecs[6]  = '{32'hFFDFF06F, 64'hFFFF_FFFF_FFFF_FFFC, FMT_J, 1'b0};
        vecs[7]  = '{32'h12345017, 64'h0000_0000_1234_5000, FMT_U, 1'b0};
        vecs[8]  = '{32'h00B50533, 64'h0, FMT_NONE, 1'b0};
        vecs[9]  = '{32'h00004501, 64'h0, FMT_NONE, 1'b1};
        vecs[10] = '{32'h0000007F, 64'h0, FMT_NONE, 1'b1};
        vecs[11] = '{32'h00000073, 64'h0, FMT_NONE, 1'b0};
        vecs[12] = '{32'h80002003, 64'hFFFF_FFFF_FFFF_F800, FMT_I, 1'b0};
`ifdef IMM_GEN_ZICSR_EN
        vecs[13] = '{32'h3002D073, 64'h5, FMT_Z, 1'b0};
        vecs[14] = '{32'hFFF29073, 64'h0000_0000_0000_0FFF, FMT_I, 1'b0};
        vecs[15] = '{32'h0000C073, 64'h0, FMT_NONE, 1'b1};
`else
        vecs[13] = '{32'h3002D073, 64'h0, FMT_NONE, 1'b0};
        vecs[14] = '{32'hFFF29073, 64'h0, FMT_NONE, 1'b0};
        vecs[15] = '{32'h0000C073, 64'h0, FMT_NONE, 1'b0};
`endif

        // Reset state
        reset_dut();
        check_flags("reset", 1'b0, 1'b1);
        check_entry("reset", '0);
        check("reset_state32", 64'(st32), 64'(BUF_EMPTY));
        check("reset_state64", 64'(st64), 64'(BUF_EMPTY));

        // Table: one instruction per cycle, result visible after the edge
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            offer(vecs[i].instr, 64'h1000 + 64'(i) * 4);
            tick();
            check_flags($sformatf("vec%0d", i), 1'b1, 1'b1);
            check_entry($sformatf("vec%0d", i),
                        {vecs[i].imm, vecs[i].fmt, vecs[i].ill, 64'h1000 + 64'(i) * 4});
        end
        in_valid = 1'b0;
        tick();
        check_flags("drain", 1'b0, 1'b1);

        // Backpressure: two absorbed, third refused, FIFO drain order
        out_ready = 1'b0;
        offer(32'h00100093, 64'h0);
        tick();
        check_flags("bp_acc0", 1'b1, 1'b1);
        offer(32'h00200113, 64'h4);
        tick();
        check_flags("bp_acc1", 1'b1, 1'b0);
        check_entry("bp_hold0", ref_entry(32'h00100093, 64'h0));
        offer(32'h00300193, 64'h8);
        tick();
        check_flags("bp_refuse", 1'b1, 1'b0);
        check_entry("bp_hold1", ref_entry(32'h00100093, 64'h0));
        out_ready = 1'b1;
        tick();
        check_flags("bp_deq0", 1'b1, 1'b1);
        check_entry("bp_out4", ref_entry(32'h00200113, 64'h4));
        tick();
        check_flags("bp_deq1", 1'b1, 1'b1);
        check_entry("bp_out8", ref_entry(32'h00300193, 64'h8));
        in_valid = 1'b0;
        tick();
        check_flags("bp_empty", 1'b0, 1'b1);

        // Flush in TWO with an offered entry
        out_ready = 1'b0;
        offer(32'h00100093, 64'h10);
        tick();
        offer(32'h00200093, 64'h14);
        tick();
        check_flags("fl_two", 1'b1, 1'b0);
        flush = 1'b1;
        offer(32'h00300093, 64'h18);
        tick();
        check_flags("fl_after", 1'b0, 1'b1);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check_flags("fl_gone", 1'b0, 1'b1);

        // Flush in ONE while an input is accepted: the input is discarded
        offer(32'h00100093, 64'h20);
        tick();
        flush = 1'b1;
        out_ready = 1'b0;
        offer(32'h00500093, 64'h24);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check_flags("fl_one", 1'b0, 1'b1);
        tick();
        check_flags("fl_one_gone", 1'b0, 1'b1);

        // Reset mid-stall (TWO) with input and flush present
        offer(32'h00100093, 64'h30);
        tick();
        offer(32'h00200093, 64'h34);
        tick();
        check_flags("rs_two", 1'b1, 1'b0);
        rst = 1'b1;
        flush = 1'b1;
        offer(32'h00700093, 64'h38);
        tick();
        check_flags("rs_mid", 1'b0, 1'b1);
        check_entry("rs_mid", '0);
        rst = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        offer(32'hFFF00093, 64'h40);
        tick();
        check_flags("rs_after", 1'b1, 1'b1);
        check_entry("rs_after", {64'hFFFF_FFFF_FFFF_FFFF, FMT_I, 1'b0, 64'h40});
        in_valid = 1'b0;
        tick();

        // Randomised traffic against the queue model
        exp_q.delete();
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            in_instr  = rand_instr();
            in_pc     = {$urandom, $urandom};
            sz = exp_q.size();
            if (sz > 0) check_entry("rnd", exp_q[0]);
            a = in_valid && (sz < 2);
            d = out_ready && (sz > 0);
            e = ref_entry(in_instr, in_pc);
            tick();
            if (flush) begin
                exp_q.delete();
            end else begin
                if (d) void'(exp_q.pop_front());
                if (a) exp_q.push_back(e);
            end
            check_flags("rnd", exp_q.size() > 0, exp_q.size() < 2);
        end
        flush = 1'b0;
        in_valid = 1'b0;

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
